// File: rtl/mem_pkg.sv
// Shared types for the two-port memory arbiter: access size, request and
// registered response descriptors.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    size_e       size;
    logic [31:0] wdata;
  } req_t;

  // The store flag rides along so a store response can return zero data
  // even though the RAM still presents the old word.
  typedef struct packed {
    logic       vld;
    logic       port;
    logic [1:0] off;
    size_e      size;
    logic       we;
    logic       err;
  } rsp_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between right-aligned requester data and the 32-bit RAM
// word: write strobes, lane replication, alignment check and load extraction.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [3:0]  wb,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  input  logic [1:0]  rsp_off,
  input  size_e       rsp_size,
  input  logic        rsp_ld,
  input  logic [31:0] ram_rdata,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  // An undefined size encoding is folded into the misalignment flag.
  always_comb begin
    wb        = 4'h0;
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE: begin
        wb        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        wb        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = off[0];
      end
      SZ_WORD: begin
        wb       = 4'hF;
        misalign = |off;
      end
      default: misalign = 1'b1;
    endcase
    if (!we) wb = 4'h0;
  end

  always_comb begin
    shifted   = ram_rdata >> {rsp_off, 3'b000};
    rdata_ext = 32'h0;
    if (rsp_ld) begin
      case (rsp_size)
        SZ_BYTE: rdata_ext = {24'h0, shifted[7:0]};
        SZ_HALF: rdata_ext = {16'h0, shifted[15:0]};
        default: rdata_ext = shifted;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Two-requester round-robin front end for a single-port synchronous RAM with
// one-cycle fixed response latency and in-band error reporting.
module mem_arbiter_ctrl
  import mem_pkg::*;
#(
  parameter int          MEMORY_BUS_WIDTH = 32,
  parameter int          SIZE             = 2048,
  parameter logic [31:0] ADDRESS          = 32'h0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [1:0]                          p_valid,
  output logic [1:0]                          p_ready,
  input  logic [1:0][31:0]                    p_addr,
  input  logic [1:0]                          p_we,
  input  logic [1:0][1:0]                     p_size,
  input  logic [1:0][MEMORY_BUS_WIDTH-1:0]    p_wdata,
  output logic [1:0]                          p_rvalid,
  output logic [1:0][MEMORY_BUS_WIDTH-1:0]    p_rdata,
  output logic [1:0]                          p_err,
  output logic                                ram_enable,
  output logic [$clog2(SIZE)-1:0]             ram_addr,
  output logic [3:0]                          ram_wb,
  output logic [MEMORY_BUS_WIDTH-1:0]         ram_wdata,
  input  logic [MEMORY_BUS_WIDTH-1:0]         ram_rdata
);

  localparam int          AW   = $clog2(SIZE);
  localparam logic [32:0] BASE = {1'b0, ADDRESS};
  localparam logic [32:0] SPAN = 33'(4 * SIZE);

  logic          last_gnt;
  logic          gnt_vld_p0;
  logic          gnt_port_p0;
  req_t          req_p0;
  logic [32:0]   rel_p0;
  logic          in_range_p0;
  logic          misalign_p0;
  logic          err_p0;
  logic          acc_p0;
  logic [3:0]    wb_p0;
  logic [31:0]   wdata_rep_p0;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  rsp_t          rsp_p1;
  logic          ld_p1;
  logic [31:0]   rdata_ext_p1;

  // Stage p0: grant, decode and drive the RAM in the acceptance cycle.
  // Grants are suppressed while reset is low so nothing leaks out combinationally.
  always_comb begin
    gnt_vld_p0  = 1'b0;
    gnt_port_p0 = 1'b0;
    if (reset) begin
      if (p_valid == 2'b11) begin
        gnt_vld_p0  = 1'b1;
        gnt_port_p0 = ~last_gnt;
      end else if (p_valid[0]) begin
        gnt_vld_p0  = 1'b1;
        gnt_port_p0 = 1'b0;
      end else if (p_valid[1]) begin
        gnt_vld_p0  = 1'b1;
        gnt_port_p0 = 1'b1;
      end
    end
  end

  always_comb begin
    req_p0.addr  = p_addr[gnt_port_p0];
    req_p0.we    = p_we[gnt_port_p0];
    req_p0.size  = size_e'(p_size[gnt_port_p0]);
    req_p0.wdata = p_wdata[gnt_port_p0];
  end

  assign rel_p0      = {1'b0, req_p0.addr} - BASE;
  assign in_range_p0 = ({1'b0, req_p0.addr} >= BASE) && (rel_p0 < SPAN);
  assign err_p0      = ~in_range_p0 | misalign_p0;
  assign acc_p0      = gnt_vld_p0 & ~err_p0;

  mem_lane_align u_lane (
    .off       (req_p0.addr[1:0]),
    .size      (req_p0.size),
    .we        (req_p0.we),
    .wdata     (req_p0.wdata),
    .wb        (wb_p0),
    .wdata_rep (wdata_rep_p0),
    .misalign  (misalign_p0),
    .rsp_off   (rsp_p1.off),
    .rsp_size  (rsp_p1.size),
    .rsp_ld    (ld_p1),
    .ram_rdata (ram_rdata),
    .rdata_ext (rdata_ext_p1)
  );

  assign p_ready    = gnt_vld_p0 ? (2'b01 << gnt_port_p0) : 2'b00;
  assign ram_enable = acc_p0;
  assign ram_addr   = acc_p0 ? rel_p0[AW+1:2] : addr_q;
  assign ram_wb     = acc_p0 ? wb_p0 : 4'h0;
  assign ram_wdata  = acc_p0 ? wdata_rep_p0 : wdata_q;

  // Stage p1: response register, aligned with the RAM read latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_gnt <= 1'b1;
      rsp_p1   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      if (gnt_vld_p0) last_gnt <= gnt_port_p0;
      rsp_p1.vld  <= gnt_vld_p0;
      rsp_p1.port <= gnt_port_p0;
      rsp_p1.off  <= req_p0.addr[1:0];
      rsp_p1.size <= req_p0.size;
      rsp_p1.we   <= req_p0.we;
      rsp_p1.err  <= err_p0;
      if (acc_p0) begin
        addr_q  <= rel_p0[AW+1:2];
        wdata_q <= wdata_rep_p0;
      end
    end
  end

  assign ld_p1 = rsp_p1.vld & ~rsp_p1.we & ~rsp_p1.err;

  always_comb begin
    p_rvalid = '0;
    p_err    = '0;
    p_rdata  = '0;
    if (rsp_p1.vld) begin
      p_rvalid[rsp_p1.port] = 1'b1;
      p_err[rsp_p1.port]    = rsp_p1.err;
      p_rdata[rsp_p1.port]  = rdata_ext_p1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Bench for mem_arbiter_ctrl: directed table, hand-written reset/arbitration
// sequences and random traffic against a byte-addressed reference model.
module tb_mem_arbiter_ctrl;

  localparam int          SIZE   = 2048;
  localparam logic [31:0] ADDR_L = 32'h0;
  localparam int          NBYTES = 4 * SIZE;

  logic                clock;
  logic                reset;
  logic [1:0]          p_valid;
  logic [1:0]          p_ready;
  logic [1:0][31:0]    p_addr;
  logic [1:0]          p_we;
  logic [1:0][1:0]     p_size;
  logic [1:0][31:0]    p_wdata;
  logic [1:0]          p_rvalid;
  logic [1:0][31:0]    p_rdata;
  logic [1:0]          p_err;
  logic                ram_enable;
  logic [10:0]         ram_addr;
  logic [3:0]          ram_wb;
  logic [31:0]         ram_wdata;
  logic [31:0]         ram_rdata;

  mem_arbiter_ctrl #(.MEMORY_BUS_WIDTH(32), .SIZE(SIZE), .ADDRESS(ADDR_L)) dut (
    .clock      (clock),
    .reset      (reset),
    .p_valid    (p_valid),
    .p_ready    (p_ready),
    .p_addr     (p_addr),
    .p_we       (p_we),
    .p_size     (p_size),
    .p_wdata    (p_wdata),
    .p_rvalid   (p_rvalid),
    .p_rdata    (p_rdata),
    .p_err      (p_err),
    .ram_enable (ram_enable),
    .ram_addr   (ram_addr),
    .ram_wb     (ram_wb),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Read-before-write RAM attached beside the controller.
  logic [31:0] ram [SIZE];
  always @(posedge clock) begin
    logic [31:0] w;
    if (ram_enable) begin
      w = ram[ram_addr];
      ram_rdata <= w;
      for (int b = 0; b < 4; b++)
        if (ram_wb[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
      ram[ram_addr] <= w;
    end
  end

  typedef struct {
    logic [1:0]       v;
    logic [1:0]       we;
    logic [1:0][1:0]  sz;
    logic [1:0][31:0] a;
    logic [1:0][31:0] wd;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [1:0]  rdy;
    logic        en;
    logic [10:0] addr;
    logic [3:0]  wb;
    logic [31:0] wdata;
    logic [1:0]  rv;
    logic [1:0]  err;
    logic [31:0] rd;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]  shadow [NBYTES];
  int          m_last;
  logic        pend_v;
  int          pend_port;
  logic        pend_err;
  logic [31:0] pend_rd;
  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'd0: return 1;
      2'd1: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic bad_req(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    if ((a % nbytes(sz)) != 0) return 1'b1;
    if (a < ADDR_L || (a - ADDR_L) >= 32'(NBYTES)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.v = '0; s.we = '0; s.sz = '0; s.a = '0; s.wd = '0;
    return s;
  endfunction

  function automatic stim_t one(input int port, input logic we, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd);
    stim_t s;
    s = idle();
    s.v[port]  = 1'b1;
    s.we[port] = we;
    s.sz[port] = sz;
    s.a[port]  = a;
    s.wd[port] = wd;
    return s;
  endfunction

  function automatic vec_t mkv(input stim_t s, input logic [1:0] rdy, input logic en,
                               input logic [10:0] addr, input logic [3:0] wb,
                               input logic [31:0] wdata, input logic [1:0] rv,
                               input logic [1:0] err, input logic [31:0] rd);
    vec_t v;
    v.s = s; v.rdy = rdy; v.en = en; v.addr = addr; v.wb = wb;
    v.wdata = wdata; v.rv = rv; v.err = err; v.rd = rd;
    return v;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int kind;
    int nb;
    s = idle();
    for (int p = 0; p < 2; p++) begin
      s.v[p]  = ($urandom_range(0, 9) < 7);
      s.we[p] = $urandom_range(0, 1);
      s.sz[p] = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      s.wd[p] = $urandom;
      nb = nbytes(s.sz[p]);
      kind = $urandom_range(0, 9);
      if (kind == 0)      s.a[p] = 32'h2000 + $urandom_range(0, 255);
      else if (kind == 1) s.a[p] = 32'(NBYTES - 4) + $urandom_range(0, 7);
      else if (kind == 2) s.a[p] = $urandom_range(0, 63);
      else                s.a[p] = $urandom_range(0, 63) & ~(nb - 1);
    end
    return s;
  endfunction

  task automatic drive(input stim_t s);
    p_valid = s.v; p_we = s.we; p_size = s.sz; p_addr = s.a; p_wdata = s.wd;
  endtask

  task automatic model_reset();
    m_last = 1; pend_v = 1'b0; pend_port = 0; pend_err = 1'b0; pend_rd = '0;
    hold_addr = '0; hold_wdata = '0;
  endtask

  // One clock of traffic, checked against the model just before the edge.
  task automatic step(input stim_t s);
    logic        gv;
    int          gp;
    int          nb;
    int          off;
    logic        e_err;
    logic        e_en;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wb;
    logic [1:0]  e_rv;
    logic [1:0]  e_er;
    logic [1:0][31:0] e_rd;
    @(negedge clock);
    drive(s);
    #1;
    e_rv = '0; e_er = '0; e_rd = '0;
    if (pend_v) begin
      e_rv[pend_port] = 1'b1;
      e_er[pend_port] = pend_err;
      e_rd[pend_port] = pend_rd;
    end
    chk("rvalid", 32'(p_rvalid), 32'(e_rv));
    chk("err", 32'(p_err), 32'(e_er));
    chk("rdata0", p_rdata[0], e_rd[0]);
    chk("rdata1", p_rdata[1], e_rd[1]);

    gv = 1'b0; gp = 0;
    if (s.v == 2'b11) begin gv = 1'b1; gp = 1 - m_last; end
    else if (s.v[0])  begin gv = 1'b1; gp = 0; end
    else if (s.v[1])  begin gv = 1'b1; gp = 1; end
    a     = s.a[gp];
    wd    = s.wd[gp];
    nb    = nbytes(s.sz[gp]);
    off   = int'(a % 4);
    e_err = gv && bad_req(a, s.sz[gp]);
    e_en  = gv && !e_err;
    e_addr  = e_en ? (a - ADDR_L) / 4 : hold_addr;
    e_wb    = '0;
    e_wdata = hold_wdata;
    if (e_en) begin
      if (s.we[gp])
        for (int i = 0; i < nb; i++) e_wb[off + i] = 1'b1;
      for (int n = 0; n < 4; n++) e_wdata[8*n +: 8] = wd[8*(n % nb) +: 8];
    end
    chk("ready", 32'(p_ready), gv ? (32'd1 << gp) : 32'd0);
    chk("ram_enable", 32'(ram_enable), 32'(e_en));
    chk("ram_addr", 32'(ram_addr), e_addr);
    chk("ram_wb", 32'(ram_wb), 32'(e_wb));
    chk("ram_wdata", ram_wdata, e_wdata);

    pend_v = gv; pend_port = gp; pend_err = e_err; pend_rd = '0;
    if (e_en && !s.we[gp])
      for (int i = 0; i < nb; i++) pend_rd[8*i +: 8] = shadow[int'(a - ADDR_L) + i];
    if (e_en && s.we[gp])
      for (int i = 0; i < nb; i++) shadow[int'(a - ADDR_L) + i] = wd[8*i +: 8];
    if (gv) m_last = gp;
    if (e_en) begin hold_addr = e_addr; hold_wdata = e_wdata; end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(one(0, 1'b0, 2'd2, 32'h10, 32'h0));
    p_valid = 2'b11;
    #1;
    chk("rst_ready", 32'(p_ready), 32'd0);
    chk("rst_rvalid", 32'(p_rvalid), 32'd0);
    chk("rst_rdata", p_rdata[0] | p_rdata[1], 32'd0);
    chk("rst_err", 32'(p_err), 32'd0);
    chk("rst_ram_enable", 32'(ram_enable), 32'd0);
    chk("rst_ram_wb", 32'(ram_wb), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    drive(idle());
  endtask

  vec_t  tbl [10];
  stim_t both;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    ram_rdata = '0;
    drive(idle());
    for (int i = 0; i < SIZE; i++) ram[i] = '0;
    for (int i = 0; i < NBYTES; i++) shadow[i] = '0;
    model_reset();

    tbl[0] = mkv(one(1, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF), 2'b10, 1'b1, 11'd4, 4'hF, 32'hDEADBEEF, 2'b00, 2'b00, 32'h0);
    tbl[1] = mkv(one(1, 1'b0, 2'd2, 32'h10, 32'h0),        2'b10, 1'b1, 11'd4, 4'h0, 32'h0,        2'b10, 2'b00, 32'h0);
    tbl[2] = mkv(one(1, 1'b1, 2'd0, 32'h13, 32'h000000AB), 2'b10, 1'b1, 11'd4, 4'h8, 32'hABABABAB, 2'b10, 2'b00, 32'hDEADBEEF);
    tbl[3] = mkv(one(1, 1'b0, 2'd2, 32'h10, 32'h0),        2'b10, 1'b1, 11'd4, 4'h0, 32'h0,        2'b10, 2'b00, 32'h0);
    tbl[4] = mkv(one(0, 1'b0, 2'd1, 32'h12, 32'h0),        2'b01, 1'b1, 11'd4, 4'h0, 32'h0,        2'b10, 2'b00, 32'hABADBEEF);
    tbl[5] = mkv(one(0, 1'b0, 2'd1, 32'h11, 32'h0),        2'b01, 1'b0, 11'd4, 4'h0, 32'h0,        2'b01, 2'b00, 32'h0000ABAD);
    tbl[6] = mkv(one(1, 1'b0, 2'd2, 32'h2000, 32'h0),      2'b10, 1'b0, 11'd4, 4'h0, 32'h0,        2'b01, 2'b01, 32'h0);
    tbl[7] = mkv(one(0, 1'b0, 2'd3, 32'h10, 32'h0),        2'b01, 1'b0, 11'd4, 4'h0, 32'h0,        2'b10, 2'b10, 32'h0);
    tbl[8] = mkv(idle(),                                    2'b00, 1'b0, 11'd4, 4'h0, 32'h0,        2'b01, 2'b01, 32'h0);
    tbl[9] = mkv(idle(),                                    2'b00, 1'b0, 11'd4, 4'h0, 32'h0,        2'b00, 2'b00, 32'h0);

    apply_reset();

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].s);
      chk($sformatf("tbl%0d_ready", i), 32'(p_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_ram_enable", i), 32'(ram_enable), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_ram_addr", i), 32'(ram_addr), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_ram_wb", i), 32'(ram_wb), 32'(tbl[i].wb));
      chk($sformatf("tbl%0d_ram_wdata", i), ram_wdata, tbl[i].wdata);
      chk($sformatf("tbl%0d_rvalid", i), 32'(p_rvalid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_err", i), 32'(p_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_rdata", i), p_rdata[0] | p_rdata[1], tbl[i].rd);
    end

    // Continuous contention alternates starting from port 0.
    apply_reset();
    both = one(0, 1'b0, 2'd2, 32'h10, 32'h0);
    both.v[1] = 1'b1; both.sz[1] = 2'd2; both.a[1] = 32'h14;
    for (int k = 0; k < 6; k++) begin
      step(both);
      chk($sformatf("rr%0d_gnt", k), 32'(p_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    step(idle());

    // Reset landing on a pending response drops it; arbitration restarts at port 0.
    step(one(0, 1'b0, 2'd2, 32'h10, 32'h0));
    @(posedge clock);
    #2;
    reset = 1'b0;
    drive(idle());
    #1;
    chk("rst_drop_rvalid", 32'(p_rvalid), 32'd0);
    chk("rst_drop_rdata", p_rdata[0] | p_rdata[1], 32'd0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    step(idle());
    chk("post_rst_rvalid", 32'(p_rvalid), 32'd0);
    step(both);
    chk("post_rst_first_gnt", 32'(p_ready), 32'd1);
    step(idle());

    for (int k = 0; k < 400; k++) step(rand_stim());
    step(idle());
    step(idle());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
